// File: rtl/noc_pkg.sv
// Shared NoC router constants and types.
// Port and VC dimensions plus small index helpers.
package noc_pkg;

  localparam int PORT_NUM  = 5;
  localparam int VC_NUM    = 2;
  localparam int VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int PORT_SIZE = $clog2(PORT_NUM);

  typedef logic [PORT_SIZE-1:0] port_t;

  function automatic logic [VC_SIZE-1:0] next_vc(
    input logic [VC_SIZE-1:0] v
  );
    return (int'(v) == VC_NUM - 1) ? '0 : v + 1'b1;
  endfunction

  function automatic port_t next_port(input port_t p);
    return (int'(p) == PORT_NUM - 1) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/input_block2switch_allocator.sv
// Request/selection bundle between the input block
// and the switch allocator.
interface input_block2switch_allocator;
  import noc_pkg::*;

  port_t              out_port       [PORT_NUM][VC_NUM];
  logic [VC_SIZE-1:0] downstream_vc  [PORT_NUM][VC_NUM];
  logic [VC_NUM-1:0]  switch_request [PORT_NUM];
  logic [VC_SIZE-1:0] vc_sel         [PORT_NUM];
  logic [PORT_NUM-1:0] valid_sel;

  modport input_block (
    output out_port,
    output downstream_vc,
    output switch_request,
    input  vc_sel,
    input  valid_sel
  );

  modport switch_allocator (
    input  out_port,
    input  downstream_vc,
    input  switch_request,
    output vc_sel,
    output valid_sel
  );

endinterface

// File: rtl/switch_allocator_round_robin_arbiter.sv
// Combinational round-robin arbiter; the pointer
// names the highest-priority requester.
module round_robin_arbiter #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] requests,
  input  logic [W-1:0] pointer,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         any_grant
);

  int j;

  // Walk from the farthest offset down so the
  // closest requester to the pointer wins last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    j         = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(pointer) + k) % N;
      if (requests[W'(j)]) begin
        grant         = '0;
        grant[W'(j)]  = 1'b1;
        grant_idx     = W'(j);
        any_grant     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Separable input-first switch allocator with
// per-(output, VC) downstream credit tracking.
module switch_allocator
  import noc_pkg::*;
#(
  parameter int BUFFER_SIZE = 8
) (
  input  logic clk,
  input  logic rst,
  input_block2switch_allocator.switch_allocator ib_if,
  input  logic [PORT_NUM-1:0]                credit_valid,
  input  logic [PORT_NUM-1:0][VC_SIZE-1:0]   credit_vc,
  output logic [PORT_NUM-1:0][PORT_SIZE-1:0] xbar_sel,
  output logic [PORT_NUM-1:0]                xbar_valid
);

  localparam int CW = $clog2(BUFFER_SIZE + 1);
  localparam logic [CW-1:0] FULL = CW'(BUFFER_SIZE);

  logic [CW-1:0]       credit   [PORT_NUM][VC_NUM];
  logic [VC_SIZE-1:0]  in_ptr   [PORT_NUM];
  port_t               out_ptr  [PORT_NUM];

  logic [VC_NUM-1:0]   eligible [PORT_NUM];
  logic [VC_NUM-1:0]   in_gnt   [PORT_NUM];
  logic [VC_SIZE-1:0]  cand_idx [PORT_NUM];
  logic [PORT_NUM-1:0] in_any;
  port_t               cand_out [PORT_NUM];
  logic [VC_SIZE-1:0]  cand_dvc [PORT_NUM];

  logic [PORT_NUM-1:0] out_req  [PORT_NUM];
  logic [PORT_NUM-1:0] out_gnt  [PORT_NUM];
  port_t               w_idx    [PORT_NUM];
  logic [PORT_NUM-1:0] out_any;
  logic [VC_SIZE-1:0]  win_dvc  [PORT_NUM];
  logic [PORT_NUM-1:0] granted;

  logic [VC_NUM-1:0]   inc      [PORT_NUM];
  logic [VC_NUM-1:0]   dec      [PORT_NUM];

  // Eligibility reads the registered count only.
  always_comb begin
    for (int i = 0; i < PORT_NUM; i++) begin
      eligible[i] = '0;
      for (int v = 0; v < VC_NUM; v++) begin
        eligible[i][v] =
          ib_if.switch_request[i][v] &&
          (ib_if.out_port[i][v] < PORT_SIZE'(PORT_NUM)) &&
          (credit[ib_if.out_port[i][v]]
                 [ib_if.downstream_vc[i][v]] != '0);
      end
    end
  end

  for (genvar i = 0; i < PORT_NUM; i++) begin : g_in
    round_robin_arbiter #(.N(VC_NUM)) u_in_arb (
      .requests  (eligible[i]),
      .pointer   (in_ptr[i]),
      .grant     (in_gnt[i]),
      .grant_idx (cand_idx[i]),
      .any_grant (in_any[i])
    );
  end

  always_comb begin
    for (int i = 0; i < PORT_NUM; i++) begin
      cand_out[i] = '0;
      cand_dvc[i] = '0;
      for (int v = 0; v < VC_NUM; v++) begin
        if (in_gnt[i][v]) begin
          cand_out[i] = ib_if.out_port[i][v];
          cand_dvc[i] = ib_if.downstream_vc[i][v];
        end
      end
    end
  end

  always_comb begin
    for (int o = 0; o < PORT_NUM; o++) begin
      out_req[o] = '0;
      for (int i = 0; i < PORT_NUM; i++) begin
        out_req[o][i] = in_any[i] &&
                        (cand_out[i] == PORT_SIZE'(o));
      end
    end
  end

  for (genvar o = 0; o < PORT_NUM; o++) begin : g_out
    round_robin_arbiter #(.N(PORT_NUM)) u_out_arb (
      .requests  (out_req[o]),
      .pointer   (out_ptr[o]),
      .grant     (out_gnt[o]),
      .grant_idx (w_idx[o]),
      .any_grant (out_any[o])
    );
  end

  always_comb begin
    granted    = '0;
    xbar_valid = '0;
    xbar_sel   = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      win_dvc[o] = cand_dvc[w_idx[o]];
      if (rst && out_any[o]) begin
        xbar_valid[o] = 1'b1;
        xbar_sel[o]   = w_idx[o];
        granted       = granted | out_gnt[o];
      end
    end
  end

  always_comb begin
    ib_if.valid_sel = granted;
    for (int i = 0; i < PORT_NUM; i++) begin
      ib_if.vc_sel[i] = granted[i] ? cand_idx[i] : '0;
    end
  end

  always_comb begin
    for (int o = 0; o < PORT_NUM; o++) begin
      inc[o] = '0;
      dec[o] = '0;
      for (int v = 0; v < VC_NUM; v++) begin
        inc[o][v] = credit_valid[o] &&
                    (credit_vc[o] == VC_SIZE'(v));
        dec[o][v] = xbar_valid[o] &&
                    (win_dvc[o] == VC_SIZE'(v));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < PORT_NUM; o++) begin
        out_ptr[o] <= '0;
        in_ptr[o]  <= '0;
        for (int v = 0; v < VC_NUM; v++) begin
          credit[o][v] <= FULL;
        end
      end
    end else begin
      for (int o = 0; o < PORT_NUM; o++) begin
        for (int v = 0; v < VC_NUM; v++) begin
          if (inc[o][v] && !dec[o][v] && credit[o][v] != FULL)
            credit[o][v] <= credit[o][v] + 1'b1;
          else if (dec[o][v] && !inc[o][v])
            credit[o][v] <= credit[o][v] - 1'b1;
        end
        if (xbar_valid[o])
          out_ptr[o] <= next_port(w_idx[o]);
        if (granted[o])
          in_ptr[o] <= next_vc(cand_idx[o]);
      end
    end
  end

  // A return onto a full counter means the neighbour lost track.
  for (genvar o = 0; o < PORT_NUM; o++) begin : g_ovf
    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
      a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst)
        !(inc[o][v] && !dec[o][v] && credit[o][v] == FULL)
      );
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator: directed
// scenarios plus random traffic against a reference model.
module tb_switch_allocator;
  import noc_pkg::*;

  localparam int P = PORT_NUM;
  localparam int V = VC_NUM;
  localparam int B = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [P-1:0]                credit_valid;
  logic [P-1:0][VC_SIZE-1:0]   credit_vc;
  logic [P-1:0][PORT_SIZE-1:0] xbar_sel;
  logic [P-1:0]                xbar_valid;

  input_block2switch_allocator ib();

  switch_allocator #(.BUFFER_SIZE(B)) dut (
    .clk          (clk),
    .rst          (rst),
    .ib_if        (ib),
    .credit_valid (credit_valid),
    .credit_vc    (credit_vc),
    .xbar_sel     (xbar_sel),
    .xbar_valid   (xbar_valid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int req [P][V];
  int opt [P][V];
  int dvc [P][V];
  int cv  [P];
  int cvc [P];

  int m_cr [P][V];
  int m_ip [P];
  int m_op [P];
  int e_cand [P];
  int e_win  [P];

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < P; i++) begin
      cv[i] = 0;
      cvc[i] = 0;
      for (int v = 0; v < V; v++) begin
        req[i][v] = 0;
        opt[i][v] = 0;
        dvc[i][v] = 0;
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < P; i++) begin
      credit_valid[i] = (cv[i] != 0);
      credit_vc[i]    = VC_SIZE'(cvc[i]);
      for (int v = 0; v < V; v++) begin
        ib.switch_request[i][v] = (req[i][v] != 0);
        ib.out_port[i][v]       = PORT_SIZE'(opt[i][v]);
        ib.downstream_vc[i][v]  = VC_SIZE'(dvc[i][v]);
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < P; i++) begin
      m_ip[i] = 0;
      m_op[i] = 0;
      for (int v = 0; v < V; v++) m_cr[i][v] = B;
    end
  endtask

  function automatic void model_eval();
    for (int i = 0; i < P; i++) begin
      e_cand[i] = -1;
      for (int k = 0; k < V; k++) begin
        int v;
        v = (m_ip[i] + k) % V;
        if (e_cand[i] < 0 && req[i][v] != 0 &&
            opt[i][v] < P && m_cr[opt[i][v]][dvc[i][v]] > 0)
          e_cand[i] = v;
      end
    end
    for (int o = 0; o < P; o++) begin
      e_win[o] = -1;
      for (int k = 0; k < P; k++) begin
        int i;
        i = (m_op[o] + k) % P;
        if (e_win[o] < 0 && e_cand[i] >= 0 &&
            opt[i][e_cand[i]] == o)
          e_win[o] = i;
      end
    end
  endfunction

  task automatic compare();
    int ev [P];
    int es [P];
    model_eval();
    for (int i = 0; i < P; i++) begin
      ev[i] = 0;
      es[i] = 0;
    end
    for (int o = 0; o < P; o++) begin
      if (e_win[o] >= 0) begin
        ev[e_win[o]] = 1;
        es[e_win[o]] = e_cand[e_win[o]];
      end
    end
    for (int i = 0; i < P; i++) begin
      check($sformatf("valid_sel[%0d]", i),
            int'(ib.valid_sel[i]), ev[i]);
      check($sformatf("vc_sel[%0d]", i),
            int'(ib.vc_sel[i]), es[i]);
    end
    for (int o = 0; o < P; o++) begin
      check($sformatf("xbar_valid[%0d]", o),
            int'(xbar_valid[o]), (e_win[o] >= 0) ? 1 : 0);
      if (e_win[o] >= 0)
        check($sformatf("xbar_sel[%0d]", o),
              int'(xbar_sel[o]), e_win[o]);
    end
  endtask

  task automatic model_update();
    for (int o = 0; o < P; o++) begin
      if (e_win[o] >= 0) begin
        int w;
        int c;
        w = e_win[o];
        c = e_cand[w];
        m_op[o] = (w + 1) % P;
        m_ip[w] = (c + 1) % V;
        m_cr[o][dvc[w][c]]--;
      end
    end
    for (int o = 0; o < P; o++) begin
      if (cv[o] != 0 && m_cr[o][cvc[o]] < B)
        m_cr[o][cvc[o]]++;
    end
  endtask

  task automatic cycle_pre();
    drive();
    #1;
    compare();
  endtask

  task automatic cycle_post();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic check_credit(int o, int v, int exp);
    check($sformatf("credit[%0d][%0d]", o, v),
          int'(dut.credit[o][v]), exp);
  endtask

  task automatic check_reset_state();
    for (int i = 0; i < P; i++) begin
      check($sformatf("rst valid_sel[%0d]", i),
            int'(ib.valid_sel[i]), 0);
      check($sformatf("rst vc_sel[%0d]", i),
            int'(ib.vc_sel[i]), 0);
      check($sformatf("rst xbar_valid[%0d]", i),
            int'(xbar_valid[i]), 0);
      check($sformatf("rst xbar_sel[%0d]", i),
            int'(xbar_sel[i]), 0);
      for (int v = 0; v < V; v++) check_credit(i, v, B);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check_reset_state();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  int seq_c [6] = '{0, 2, 4, 0, 2, 4};

  initial begin
    clear_stim();
    req[0][0] = 1;
    opt[0][0] = 1;
    req[3][1] = 1;
    opt[3][1] = 4;
    drive();
    model_reset();
    @(negedge clk);
    do_reset();

    // Idle after reset
    clear_stim();
    cycle_pre();
    cycle_post();
    for (int o = 0; o < P; o++)
      for (int v = 0; v < V; v++) check_credit(o, v, B);

    // Single request, same-cycle grant
    req[1][1] = 1;
    opt[1][1] = 3;
    dvc[1][1] = 0;
    cycle_pre();
    check("single valid_sel[1]", int'(ib.valid_sel[1]), 1);
    check("single vc_sel[1]", int'(ib.vc_sel[1]), 1);
    check("single xbar_sel[3]", int'(xbar_sel[3]), 1);
    check("single xbar_valid[3]", int'(xbar_valid[3]), 1);
    cycle_post();
    check_credit(3, 0, 7);

    // Output contention on port 2
    do_reset();
    clear_stim();
    for (int i = 0; i < P; i += 2) begin
      req[i][0] = 1;
      opt[i][0] = 2;
    end
    for (int k = 0; k < 6; k++) begin
      cycle_pre();
      check("contend xbar_sel[2]", int'(xbar_sel[2]), seq_c[k]);
      check("contend one valid", $countones(xbar_valid), 1);
      cycle_post();
    end

    // VC fairness at one input
    do_reset();
    clear_stim();
    req[0][0] = 1;
    opt[0][0] = 0;
    req[0][1] = 1;
    opt[0][1] = 1;
    for (int k = 0; k < 4; k++) begin
      cycle_pre();
      check("fair vc_sel[0]", int'(ib.vc_sel[0]), k % 2);
      cycle_post();
    end

    // Credit exhaustion and recovery
    do_reset();
    clear_stim();
    req[1][0] = 1;
    opt[1][0] = 4;
    dvc[1][0] = 1;
    for (int k = 0; k < 10; k++) begin
      cycle_pre();
      check("exhaust valid_sel[1]", int'(ib.valid_sel[1]),
            (k < 8) ? 1 : 0);
      cycle_post();
    end
    check_credit(4, 1, 0);
    cv[4] = 1;
    cvc[4] = 1;
    cycle_pre();
    check("return@0 valid_sel[1]", int'(ib.valid_sel[1]), 0);
    cycle_post();
    cv[4] = 0;
    cycle_pre();
    check("resume valid_sel[1]", int'(ib.valid_sel[1]), 1);
    cycle_post();
    check_credit(4, 1, 0);

    // Simultaneous return and grant at 5
    do_reset();
    clear_stim();
    req[0][0] = 1;
    opt[0][0] = 3;
    for (int k = 0; k < 3; k++) begin
      cycle_pre();
      cycle_post();
    end
    check_credit(3, 0, 5);
    cv[3] = 1;
    cvc[3] = 0;
    cycle_pre();
    check("both valid_sel[0]", int'(ib.valid_sel[0]), 1);
    cycle_post();
    check_credit(3, 0, 5);

    // Random traffic with a mid-burst async reset
    do_reset();
    for (int k = 0; k < 400; k++) begin
      clear_stim();
      for (int i = 0; i < P; i++) begin
        for (int v = 0; v < V; v++) begin
          req[i][v] = ($urandom_range(9) < 6) ? 1 : 0;
          opt[i][v] = $urandom_range(P - 1);
          dvc[i][v] = $urandom_range(V - 1);
        end
        if ($urandom_range(1) == 1) begin
          int rv;
          rv = $urandom_range(V - 1);
          if (m_cr[i][rv] < B) begin
            cv[i] = 1;
            cvc[i] = rv;
          end
        end
      end
      if (k == 200) begin
        drive();
        #2;
        do_reset();
      end else begin
        cycle_pre();
        cycle_post();
      end
    end
    for (int o = 0; o < P; o++)
      for (int v = 0; v < V; v++) check_credit(o, v, m_cr[o][v]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Switch-allocation (SA) stage of the router; it is the allocator end of the input_block2switch_allocator interface.
- Takes per-VC switch requests (out_port, downstream_vc) from all input ports and issues per-input VC selections back to the input block.
- Drives crossbar select and valid per output port.
- Tracks downstream buffer credits per output port and per downstream VC, so it never grants a flit that the next router cannot accept.
- Separable input-first allocator with round-robin fairness at both stages.

Parameters:
- BUFFER_SIZE, 8, flit slots per downstream VC; also the initial and maximum credit count per (output port, VC).
- PORT_NUM, VC_NUM, VC_SIZE, port_t: taken from noc_pkg, not module parameters.

Ports:
- clk  input  1  router clock.
- rst  input  1  asynchronous, active-low reset.
- ib_if  modport  input_block2switch_allocator.switch_allocator  drives vc_sel/valid_sel; receives out_port, downstream_vc, switch_request.
- credit_valid  input  [PORT_NUM]  per output port: the downstream router freed one slot.
- credit_vc  input  [PORT_NUM][VC_SIZE]  VC the returned credit belongs to.
- xbar_sel  output  [PORT_NUM][$clog2(PORT_NUM)]  per output port: winning input port index.
- xbar_valid  output  [PORT_NUM]  per output port: a flit traverses the crossbar this cycle.

Behaviour:
- Reset (async, rst=0):
  - All credit counters = BUFFER_SIZE.
  - All round-robin pointers = 0.
  - Outputs are combinational from state and inputs. With rst=0, valid_sel, xbar_valid and xbar_sel are forced to 0 and vc_sel is 0.
- Eligibility, for VC v of input port i:
  - switch_request[i][v]=1, and
  - credit[out_port[i][v]][downstream_vc[i][v]] > 0.
- Stage 1 (input arbitration):
  - Per input port i, a round-robin arbiter over eligible VCs, starting at in_ptr[i].
  - Produces candidate VC c_i and its target output o_i.
- Stage 2 (output arbitration):
  - Per output port o, a round-robin arbiter over input ports whose candidate targets o, starting at out_ptr[o].
  - The winner is input w_o.
- Outputs, same cycle as the requests (zero-cycle combinational latency):
  - For each winner: valid_sel[w_o]=1, vc_sel[w_o]=c_w, xbar_sel[o]=w_o, xbar_valid[o]=1.
  - Inputs that did not win: valid_sel=0, vc_sel=0.
- Pointer update, on the rising edge of clk:
  - Granted input i: in_ptr[i] = (c_i+1) mod VC_NUM.
  - Input whose candidate lost stage 2: in_ptr unchanged.
  - Output o with a grant: out_ptr[o] = (w_o+1) mod PORT_NUM.
  - Idle ports keep their pointers.
- Credits, on the rising edge of clk:
  - Per (o, v): credit += (credit_valid[o] && credit_vc[o]==v), and credit -= (grant at o with downstream_vc==v).
  - A simultaneous increment and decrement on the same counter leaves it unchanged.
  - Counter width is $clog2(BUFFER_SIZE+1).
- Boundary conditions:
  - Credit 0: the request is ineligible, no grant, and the pointer does not advance.
  - Credit at BUFFER_SIZE with a credit return and no grant: the counter saturates. This is a protocol error; flag it with an assertion.
  - A credit return and a grant landing on the same counter at 0: the request is still ineligible in that cycle (eligibility uses the registered count).
- Invariants:
  - At most one grant per input port and at most one per output port per cycle.
  - No two outputs select the same input.
- Reset mid-operation: state returns to reset values immediately. Credits in flight are discarded; the neighbour is reset in the same domain.

Decomposition:
- noc_pkg:
  - PORT_NUM, VC_NUM, VC_SIZE, port_t (already present).
  - Add a PORT_SIZE constant ($clog2(PORT_NUM)) for xbar_sel.
  - BUFFER_SIZE stays a module parameter.
- Sub-module: round_robin_arbiter #(N).
  - Ports: requests [N], pointer [$clog2(N)].
  - Outputs: one-hot grant [N], grant index, any-grant flag. Combinational.
  - Instantiated PORT_NUM times for stage 1 (N=VC_NUM) and PORT_NUM times for stage 2 (N=PORT_NUM).
  - Pointer registers live in switch_allocator.

Test Plan:
Bench uses PORT_NUM=5, VC_NUM=2, BUFFER_SIZE=8.
- Reset then idle: all switch_request=0 → valid_sel all 0, xbar_valid all 0; every credit reads 8 (via hierarchical check).
- Single request: input 1, VC 1 requests out_port 3, downstream_vc 0 → same cycle valid_sel[1]=1, vc_sel[1]=1, xbar_sel[3]=1, xbar_valid[3]=1; next cycle credit[3][0]=7.
- Output contention: inputs 0, 2, 4 hold requests to output 2 for 6 cycles → grants go 0,2,4,0,2,4; exactly one xbar_valid per cycle.
- VC fairness: input 0 has both VCs requesting different free outputs for 4 cycles → vc_sel goes 0,1,0,1.
- Credit exhaustion: input 1, VC 0 requests output 4, VC 1 for 10 cycles with no credit returns → 8 grants, then valid_sel[1]=0. Assert credit_valid[4]=1, credit_vc[4]=1 for one cycle → the grant resumes the following cycle.
- Simultaneous credit return and grant on the same counter at value 5 → it stays 5. Async reset asserted mid-burst → outputs go to 0 before the next clk edge, and credits return to 8.
